// File: rtl/mmio_port_hub.sv
// CPU-facing register hub for 2**PORT_EXP peripheral ports: reads return one cycle after the strobe, and writes take effect on the strobe edge.
// TX uses a per-port valid/ready handshake; a commit to a stalled port is dropped and flagged.
module mmio_port_hub #(
  parameter int                DATA_W    = 16,
  parameter int                ADDR_W    = 16,
  parameter int                PORT_EXP  = 3,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 16'h0,
  localparam int               PORTS     = 2**PORT_EXP
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               read,
  input  logic                               write,
  input  logic [ADDR_W-1:0]                  addr,
  input  logic [DATA_W-1:0]                  d_in,
  output logic [DATA_W-1:0]                  d_out,
  output logic                               rd_valid,
  output logic                               irq,
  output logic [PORTS-1:0][2*DATA_W-1:0]     port_tx_data,
  output logic [PORTS-1:0]                   port_tx_valid,
  input  logic [PORTS-1:0]                   port_tx_ready,
  input  logic [PORTS-1:0][DATA_W-1:0]       port_rx_data,
  input  logic [PORTS-1:0]                   port_rx_strobe
);

  localparam logic [1:0]        REG_LO  = 2'd0;
  localparam logic [1:0]        REG_HI  = 2'd1;
  localparam logic [1:0]        REG_ST  = 2'd2;
  localparam logic [1:0]        REG_RX  = 2'd3;
  localparam logic [ADDR_W-1:0] WIN     = ADDR_W'(4*PORTS);

  logic [PORTS-1:0][DATA_W-1:0] r_lo;
  logic [PORTS-1:0][DATA_W-1:0] r_rx_data;
  logic [PORTS-1:0]             r_rx_valid;
  logic [PORTS-1:0]             r_rx_ovr;
  logic [PORTS-1:0]             r_tx_drop;
  logic [PORTS-1:0]             r_rx_ie;

  logic [ADDR_W-1:0]   w_off;
  logic                w_hit;
  logic [PORT_EXP-1:0] w_port;
  logic [1:0]          w_reg;
  logic [PORTS-1:0]    w_wsel;
  logic [PORTS-1:0]    w_pop;
  logic [DATA_W-1:0]   w_rd_dat;

  assign w_off  = addr - BASE_ADDR;
  assign w_hit  = (addr >= BASE_ADDR) && (w_off < WIN);
  assign w_port = w_off[PORT_EXP+1:2];
  assign w_reg  = w_off[1:0];
  assign w_wsel = (write && w_hit) ? (PORTS'(1) << w_port) : '0;
  assign w_pop  = (read && w_hit && w_reg == REG_RX) ? (PORTS'(1) << w_port) : '0;

  // Read mux sees pre-write state, so a same-cycle write never leaks into d_out.
  always_comb begin
    w_rd_dat = '0;
    case (w_reg)
      REG_LO: w_rd_dat = r_lo[w_port];
      REG_HI: w_rd_dat = port_tx_data[w_port][2*DATA_W-1:DATA_W];
      REG_ST: w_rd_dat[4:0] = {r_rx_ie[w_port], r_tx_drop[w_port], r_rx_ovr[w_port],
                               r_rx_valid[w_port], port_tx_valid[w_port]};
      default: w_rd_dat = r_rx_data[w_port];
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d_out    <= '0;
      rd_valid <= 1'b0;
      irq      <= 1'b0;
    end else begin
      rd_valid <= read;
      if (read) d_out <= w_hit ? w_rd_dat : '0;
      irq <= |(r_rx_valid & r_rx_ie);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      port_tx_data  <= '0;
      port_tx_valid <= '0;
      r_lo          <= '0;
      r_rx_data     <= '0;
      r_rx_valid    <= '0;
      r_rx_ovr      <= '0;
      r_tx_drop     <= '0;
      r_rx_ie       <= '0;
    end else begin
      for (int i = 0; i < PORTS; i++) begin
        if (w_wsel[i] && w_reg == REG_HI) begin
          if (port_tx_valid[i] && !port_tx_ready[i]) begin
            r_tx_drop[i] <= 1'b1;
          end else begin
            port_tx_data[i]  <= {d_in, r_lo[i]};
            port_tx_valid[i] <= 1'b1;
          end
        end else if (port_tx_valid[i] && port_tx_ready[i]) begin
          port_tx_valid[i] <= 1'b0;
        end
        if (w_wsel[i] && w_reg == REG_LO) r_lo[i] <= d_in;
        if (w_wsel[i] && w_reg == REG_ST) begin
          r_rx_ie[i] <= d_in[4];
          if (d_in[3]) r_tx_drop[i] <= 1'b0;
        end
        if (w_wsel[i] && w_reg == REG_RX && d_in[2]) r_rx_ovr[i] <= 1'b0;
        // A pop frees the slot in the same cycle, so a coinciding strobe is not an overrun.
        if (port_rx_strobe[i]) begin
          if (!r_rx_valid[i] || w_pop[i]) begin
            r_rx_data[i]  <= port_rx_data[i];
            r_rx_valid[i] <= 1'b1;
          end else begin
            r_rx_ovr[i] <= 1'b1;
          end
        end else if (w_pop[i]) begin
          r_rx_valid[i] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_mmio_port_hub.sv
module tb_mmio_port_hub;
  localparam int BASE = 'h100;

  logic             clk = 1'b0;
  logic             rst;
  logic             read, write;
  logic [15:0]      addr, d_in;
  logic [15:0]      d_out;
  logic             rd_valid, irq;
  logic [7:0][31:0] port_tx_data;
  logic [7:0]       port_tx_valid, port_tx_ready, port_rx_strobe;
  logic [7:0][15:0] port_rx_data;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state, one entry per port
  logic [15:0] m_lo[8], m_txhi[8], m_txlo[8], m_rxd[8];
  bit          m_txv[8], m_rxv[8], m_ovr[8], m_drop[8], m_ie[8];
  bit          m_irq, m_rdv;
  logic [15:0] m_dout;

  mmio_port_hub #(.DATA_W(16), .ADDR_W(16), .PORT_EXP(3), .BASE_ADDR(16'h0100)) dut (
    .clk(clk), .rst(rst), .read(read), .write(write), .addr(addr), .d_in(d_in),
    .d_out(d_out), .rd_valid(rd_valid), .irq(irq),
    .port_tx_data(port_tx_data), .port_tx_valid(port_tx_valid), .port_tx_ready(port_tx_ready),
    .port_rx_data(port_rx_data), .port_rx_strobe(port_rx_strobe)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      m_lo[i] = 0; m_txhi[i] = 0; m_txlo[i] = 0; m_rxd[i] = 0;
      m_txv[i] = 0; m_rxv[i] = 0; m_ovr[i] = 0; m_drop[i] = 0; m_ie[i] = 0;
    end
    m_irq = 0; m_rdv = 0; m_dout = 0;
  endtask

  function automatic logic [15:0] reg_value(input int p, input int r);
    case (r)
      0: return m_lo[p];
      1: return m_txhi[p];
      2: return {11'd0, m_ie[p], m_drop[p], m_ovr[p], m_rxv[p], m_txv[p]};
      default: return m_rxd[p];
    endcase
  endfunction

  // One clock edge worth of bus and port activity, applied to the model.
  task automatic model_step();
    int off, p, r, pop;
    bit hit, nirq;
    off = int'(addr) - BASE;
    hit = (off >= 0) && (off < 32);
    p   = hit ? off / 4 : 0;
    r   = hit ? off % 4 : 0;
    nirq = 0;
    for (int i = 0; i < 8; i++) if (m_rxv[i] && m_ie[i]) nirq = 1;
    m_rdv = read;
    if (read) m_dout = hit ? reg_value(p, r) : 16'h0;
    pop = (read && hit && r == 3) ? p : -1;
    for (int i = 0; i < 8; i++) begin
      bit wsel;
      wsel = write && hit && (p == i);
      if (wsel && r == 1) begin
        if (m_txv[i] && !port_tx_ready[i]) m_drop[i] = 1;
        else begin m_txhi[i] = d_in; m_txlo[i] = m_lo[i]; m_txv[i] = 1; end
      end else if (m_txv[i] && port_tx_ready[i]) m_txv[i] = 0;
      if (wsel && r == 0) m_lo[i] = d_in;
      if (wsel && r == 2) begin m_ie[i] = d_in[4]; if (d_in[3]) m_drop[i] = 0; end
      if (wsel && r == 3 && d_in[2]) m_ovr[i] = 0;
      if (port_rx_strobe[i]) begin
        if (!m_rxv[i] || pop == i) begin m_rxd[i] = port_rx_data[i]; m_rxv[i] = 1; end
        else m_ovr[i] = 1;
      end else if (pop == i) m_rxv[i] = 0;
    end
    m_irq = nirq;
  endtask

  task automatic compare_all();
    logic [255:0] etd;
    logic [7:0]   etv;
    for (int i = 0; i < 8; i++) begin
      etd[i*32 +: 32] = {m_txhi[i], m_txlo[i]};
      etv[i] = m_txv[i];
    end
    chk("d_out", d_out, m_dout);
    chk("rd_valid", rd_valid, m_rdv);
    chk("irq", irq, m_irq);
    chk("tx_valid", port_tx_valid, etv);
    chk("tx_data", port_tx_data, etd);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic op(input bit rd, input bit wr, input int a, input logic [15:0] d);
    read = rd; write = wr; addr = 16'(a); d_in = d;
    tick();
    read = 0; write = 0;
  endtask

  task automatic strobe(input int p, input logic [15:0] d);
    port_rx_data[p] = d; port_rx_strobe[p] = 1'b1;
    tick();
    port_rx_strobe = '0;
  endtask

  initial begin
    rst = 1; read = 0; write = 0; addr = 0; d_in = 0;
    port_tx_ready = '0; port_rx_strobe = '0; port_rx_data = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 compare_all();
    rst = 0;

    // TX basic on port 2
    op(0, 1, BASE + 8, 16'h1234);
    op(0, 1, BASE + 9, 16'hABCD);
    chk("tx2_word", port_tx_data[2], 32'hABCD1234);
    chk("tx2_valid_set", port_tx_valid[2], 1'b1);
    port_tx_ready[2] = 1; tick(); port_tx_ready = '0;
    chk("tx2_valid_clr", port_tx_valid[2], 1'b0);

    // TX busy: second commit dropped while stalled
    op(0, 1, BASE + 8, 16'h1111); op(0, 1, BASE + 9, 16'h2222);
    op(0, 1, BASE + 8, 16'h3333); op(0, 1, BASE + 9, 16'h4444);
    chk("tx2_kept", port_tx_data[2], 32'h22221111);
    op(1, 0, BASE + 10, 0);
    chk("drop_set", d_out[3], 1'b1);
    op(0, 1, BASE + 10, 16'h0008);
    op(1, 0, BASE + 10, 0);
    chk("drop_clr", d_out[3], 1'b0);
    port_tx_ready[2] = 1; tick(); port_tx_ready = '0;

    // RX and irq on port 5
    op(0, 1, BASE + 22, 16'h0010);
    strobe(5, 16'h00C3);
    tick();
    chk("irq_set", irq, 1'b1);
    op(1, 0, BASE + 23, 0);
    chk("rx5_data", d_out, 16'h00C3);
    chk("rx5_rdv", rd_valid, 1'b1);
    tick();
    chk("irq_clr", irq, 1'b0);

    // Overrun, then strobe coinciding with pop on port 1
    strobe(1, 16'h0011);
    strobe(1, 16'h0022);
    op(1, 0, BASE + 6, 0);
    chk("ovr_set", d_out[2:1], 2'b11);
    op(0, 1, BASE + 7, 16'h0004);
    port_rx_data[1] = 16'h0044; port_rx_strobe[1] = 1;
    op(1, 0, BASE + 7, 0);
    port_rx_strobe = '0;
    chk("pop_old", d_out, 16'h0011);
    op(1, 0, BASE + 6, 0);
    chk("pop_keep", d_out[2:1], 2'b01);
    op(1, 0, BASE + 7, 0);
    chk("pop_new", d_out, 16'h0044);

    // Decode bounds
    op(1, 0, 'h00FF, 0);
    chk("lo_bound", d_out, 16'h0);
    op(1, 0, BASE + 1, 0);
    op(1, 0, 'h0120, 0);
    chk("hi_bound", d_out, 16'h0);
    chk("hi_bound_rdv", rd_valid, 1'b1);
    op(0, 1, 'h00FF, 16'hFFFF);
    op(0, 1, 'h0120, 16'hFFFF);
    op(0, 1, 'h0123, 16'hFFFF);

    // Randomised traffic around and inside the window
    for (int n = 0; n < 3000; n++) begin
      read  = ($urandom_range(0, 2) == 0);
      write = ($urandom_range(0, 2) == 0);
      addr  = 16'($urandom_range(BASE - 4, BASE + 35));
      d_in  = 16'($urandom);
      port_tx_ready  = 8'($urandom);
      port_rx_strobe = 8'($urandom) & 8'($urandom);
      for (int i = 0; i < 8; i++) port_rx_data[i] = 16'($urandom);
      tick();
    end
    read = 0; write = 0; port_tx_ready = '0; port_rx_strobe = '0;

    // Asynchronous reset while a TX word is pending
    op(0, 1, BASE + 12, 16'h5555);
    op(0, 1, BASE + 13, 16'h6666);
    op(0, 1, BASE + 14, 16'h0010);
    strobe(3, 16'h0077);
    op(1, 0, BASE + 13, 0);
    chk("pre_rst_txv", port_tx_valid[3], 1'b1);
    @(negedge clk);
    #2 rst = 1;
    #1;
    chk("arst_txv", port_tx_valid, 8'h00);
    chk("arst_irq", irq, 1'b0);
    chk("arst_rdv", rd_valid, 1'b0);
    chk("arst_dout", d_out, 16'h0);
    model_reset();
    compare_all();
    @(posedge clk);
    #1 rst = 0;
    op(1, 0, BASE + 14, 0);
    op(1, 0, BASE + 12, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
